// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage redirect/stall/flush sequencer
// Owns the front-end redirect priority: branch > interrupt > stall > normal.
module fetch_sequencer #(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [2:0] IMM_OPCODE   = 3'b110,
  parameter logic [4:0] HLT_OPCODE   = 5'b00001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        interrupt,
  input  logic [15:0] reset_vector,
  input  logic [15:0] interrupt_vector,
  input  logic [15:0] instruction,
  input  logic [31:0] pc_plus_one,
  output logic        pc_enable,
  output logic        pc_write,
  output logic [15:0] pc_write_back_value,
  output logic        clear_instruction,
  output logic        imm_pending,
  output logic        int_ack,
  output logic [15:0] int_return_pc,
  output logic        halted
);

  typedef enum logic [2:0] {BOOT, RUN, IMM, FLUSH, HALT} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state, state_next;
  logic [2:0] flush_cnt, cnt_next;
  logic       take_int;

  logic unused_inputs;
  assign unused_inputs = ^{pc_plus_one[31:16], instruction[10:0]};

  always_comb begin
    state_next          = state;
    cnt_next            = flush_cnt;
    take_int            = 1'b0;
    pc_enable           = 1'b0;
    pc_write            = 1'b0;
    pc_write_back_value = 16'h0000;
    clear_instruction   = 1'b0;
    // Outputs are forced low for the whole time reset is held.
    if (reset) begin
      if (state == BOOT) begin
        pc_enable           = 1'b1;
        pc_write            = 1'b1;
        pc_write_back_value = reset_vector;
        clear_instruction   = 1'b1;
        state_next          = FLUSH;
        cnt_next            = FLUSH_LOAD;
      end else if (branch_taken) begin
        pc_enable           = 1'b1;
        pc_write            = 1'b1;
        pc_write_back_value = branch_target;
        clear_instruction   = 1'b1;
        state_next          = FLUSH;
        cnt_next            = FLUSH_LOAD;
      end else if (interrupt && (state == RUN || state == HALT)) begin
        pc_enable           = 1'b1;
        pc_write            = 1'b1;
        pc_write_back_value = interrupt_vector;
        clear_instruction   = 1'b1;
        take_int            = 1'b1;
        state_next          = FLUSH;
        cnt_next            = FLUSH_LOAD;
      end else begin
        case (state)
          RUN: begin
            if (!stall) begin
              pc_enable = 1'b1;
              if (instruction[15:13] == IMM_OPCODE)
                state_next = IMM;
              else if (instruction[15:11] == HLT_OPCODE)
                state_next = HALT;
            end
          end
          IMM: begin
            if (!stall) begin
              pc_enable  = 1'b1;
              state_next = RUN;
            end
          end
          FLUSH: begin
            // Stall does not hold the flush window; the counter always runs.
            pc_enable         = 1'b1;
            clear_instruction = 1'b1;
            if (flush_cnt <= 3'd1) begin
              cnt_next   = 3'd0;
              state_next = RUN;
            end else begin
              cnt_next = flush_cnt - 3'd1;
            end
          end
          HALT: begin
            pc_enable = 1'b0;
          end
          default: begin
            state_next = BOOT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BOOT;
      flush_cnt     <= 3'd0;
      imm_pending   <= 1'b0;
      int_ack       <= 1'b0;
      int_return_pc <= 16'h0000;
      halted        <= 1'b0;
    end else begin
      state       <= state_next;
      flush_cnt   <= cnt_next;
      imm_pending <= (state_next == IMM);
      halted      <= (state_next == HALT);
      int_ack     <= take_int;
      // From RUN the word in flight is discarded, so return to its own PC.
      if (take_int)
        int_return_pc <= (state == HALT) ? pc_plus_one[15:0]
                                         : pc_plus_one[15:0] - 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector-table bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall, branch_taken, interrupt;
  logic [15:0] branch_target, reset_vector, interrupt_vector, instruction;
  logic [31:0] pc_plus_one;
  logic        pc_enable, pc_write, clear_instruction;
  logic [15:0] pc_write_back_value;
  logic        imm_pending, int_ack, halted;
  logic [15:0] int_return_pc;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .interrupt           (interrupt),
    .reset_vector        (reset_vector),
    .interrupt_vector    (interrupt_vector),
    .instruction         (instruction),
    .pc_plus_one         (pc_plus_one),
    .pc_enable           (pc_enable),
    .pc_write            (pc_write),
    .pc_write_back_value (pc_write_back_value),
    .clear_instruction   (clear_instruction),
    .imm_pending         (imm_pending),
    .int_ack             (int_ack),
    .int_return_pc       (int_return_pc),
    .halted              (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        st, br, irq;
    logic [15:0] instr, ppo, tgt;
    logic        en, wr;
    logic [15:0] val;
    logic        clr, imm, ack, hlt;
    logic [15:0] rpc;
  } vec_t;

  function automatic vec_t v(logic st, logic br, logic irq, logic [15:0] instr,
                             logic [15:0] ppo, logic [15:0] tgt, logic en, logic wr,
                             logic [15:0] val, logic clr, logic imm, logic ack,
                             logic hlt, logic [15:0] rpc);
    vec_t r;
    r.st = st; r.br = br; r.irq = irq; r.instr = instr; r.ppo = ppo; r.tgt = tgt;
    r.en = en; r.wr = wr; r.val = val; r.clr = clr; r.imm = imm; r.ack = ack;
    r.hlt = hlt; r.rpc = rpc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic wr,
                         input logic [15:0] val, input logic clr, input logic imm,
                         input logic ack, input logic hlt, input logic [15:0] rpc);
    chk({tag, ".pc_enable"}, 16'(pc_enable), 16'(en));
    chk({tag, ".pc_write"}, 16'(pc_write), 16'(wr));
    chk({tag, ".value"}, pc_write_back_value, val);
    chk({tag, ".clear"}, 16'(clear_instruction), 16'(clr));
    chk({tag, ".imm_pending"}, 16'(imm_pending), 16'(imm));
    chk({tag, ".int_ack"}, 16'(int_ack), 16'(ack));
    chk({tag, ".halted"}, 16'(halted), 16'(hlt));
    chk({tag, ".int_return_pc"}, int_return_pc, rpc);
  endtask

  task automatic drive(input logic st, input logic br, input logic irq,
                       input logic [15:0] instr, input logic [31:0] ppo,
                       input logic [15:0] tgt);
    stall = st; branch_taken = br; interrupt = irq;
    instruction = instr; pc_plus_one = ppo; branch_target = tgt;
  endtask

  localparam logic [15:0] I = 16'h2000;
  vec_t vecs[19];

  initial begin
    vecs[0]  = v(1, 1, 1, I,       16'h0010, 16'h0700, 1, 1, 16'h0020, 1, 0, 0, 0, 16'h0000);
    vecs[1]  = v(1, 0, 0, 16'hC123, 16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[2]  = v(1, 0, 0, I,       16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[3]  = v(1, 0, 0, I,       16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[4]  = v(1, 0, 0, I,       16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[5]  = v(1, 1, 0, I,       16'h0010, 16'h0080, 1, 1, 16'h0080, 1, 0, 0, 0, 16'h0000);
    vecs[6]  = v(0, 1, 0, I,       16'h0010, 16'h0090, 1, 1, 16'h0090, 1, 0, 0, 0, 16'h0000);
    vecs[7]  = v(0, 0, 0, I,       16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[8]  = v(0, 0, 0, 16'hC123, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[9]  = v(1, 0, 0, I,       16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000);
    vecs[10] = v(0, 0, 1, 16'h0800, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000);
    vecs[11] = v(0, 0, 1, I,       16'h0045, 16'h0000, 1, 1, 16'h0200, 1, 0, 0, 0, 16'h0000);
    vecs[12] = v(0, 0, 0, I,       16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 1, 0, 16'h0044);
    vecs[13] = v(0, 0, 0, 16'hC123, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0044);
    vecs[14] = v(0, 1, 0, I,       16'h0010, 16'h0300, 1, 1, 16'h0300, 1, 1, 0, 0, 16'h0044);
    vecs[15] = v(0, 0, 0, I,       16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0044);
    vecs[16] = v(0, 1, 1, I,       16'h0010, 16'h0400, 1, 1, 16'h0400, 1, 0, 0, 0, 16'h0044);
    vecs[17] = v(0, 0, 0, I,       16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0044);
    vecs[18] = v(0, 0, 0, 16'h0800, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0044);

    reset = 1'b0;
    reset_vector = 16'h0020;
    interrupt_vector = 16'h0200;
    drive(1, 1, 1, 16'hC123, 32'h0000_0045, 16'h0123);
    repeat (2) @(negedge clk);
    #2;
    chk_all("reset", 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].irq, vecs[i].instr,
            {16'h0000, vecs[i].ppo}, vecs[i].tgt);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].wr, vecs[i].val,
              vecs[i].clr, vecs[i].imm, vecs[i].ack, vecs[i].hlt, vecs[i].rpc);
      @(negedge clk);
    end

    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 0, 0, 16'hC123, 32'h0000_0010, 16'h0000);
      #2;
      chk_all($sformatf("halt%0d", i), 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0044);
      @(negedge clk);
    end

    drive(0, 0, 1, I, 32'hABCD_0077, 16'h0000);
    #2;
    chk_all("halt_irq", 1, 1, 16'h0200, 1, 0, 0, 1, 16'h0044);
    @(negedge clk);
    drive(0, 0, 0, I, 32'h0000_0010, 16'h0000);
    #2;
    chk_all("halt_ack", 1, 0, 16'h0000, 1, 0, 1, 0, 16'h0077);
    @(negedge clk);
    #2;
    chk_all("post_isr_run", 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0077);
    @(negedge clk);

    drive(0, 1, 0, I, 32'h0000_0010, 16'h0500);
    #2;
    chk_all("pre_reset_br", 1, 1, 16'h0500, 1, 0, 0, 0, 16'h0077);
    @(negedge clk);
    drive(0, 0, 0, I, 32'h0000_0010, 16'h0000);
    #1;
    reset = 1'b0;
    #1;
    chk_all("reset_async", 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    #2;
    chk_all("reset_held", 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk_all("reboot", 1, 1, 16'h0020, 1, 0, 0, 0, 16'h0000);
    @(negedge clk);
    #2;
    chk_all("reboot_flush", 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    @(negedge clk);
    #2;
    chk_all("reboot_run", 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch stage PC/instruction-register unit: drives its pc_enable, pc_write, pc_write_back_value and clear_instruction.
- Sequences boot-vector load, hazard stalls, branch redirect with flush, two-word (immediate) instructions, HLT, and interrupt vectoring.
- Sits between the hazard/branch/interrupt logic and the fetch unit; holds the only redirect-priority decision in the front end.

Parameters:
- FLUSH_CYCLES, 1, extra cycles clear_instruction stays high after a redirect (1..7).
- IMM_OPCODE, 3'b110, value of instruction[15:13] marking a two-word instruction.
- HLT_OPCODE, 5'b00001, value of instruction[15:11] marking HLT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall request from the decode hazard unit.
- branch_taken  input  1  execute-stage redirect request.
- branch_target  input  16  redirect address.
- interrupt  input  1  level interrupt request.
- reset_vector  input  16  boot PC (memory word 0).
- interrupt_vector  input  16  ISR PC (memory word 1).
- instruction  input  16  word currently output by the fetch unit.
- pc_plus_one  input  32  next-PC value from the fetch unit.
- pc_enable  output  1  to fetch unit.
- pc_write  output  1  to fetch unit.
- pc_write_back_value  output  16  to fetch unit.
- clear_instruction  output  1  to fetch unit.
- imm_pending  output  1  registered; current fetch is an immediate word.
- int_ack  output  1  registered one-cycle pulse on interrupt entry.
- int_return_pc  output  16  registered return address captured on entry.
- halted  output  1  registered; core is halted.

Behaviour:
- States: BOOT, RUN, IMM, FLUSH, HALT. While reset is low, state=BOOT, flush counter=0, and every output is 0.
- Control outputs (pc_enable, pc_write, pc_write_back_value, clear_instruction) are combinational from state and inputs. All other outputs are registered.
- BOOT (first cycle after reset release):
  - pc_enable=1, pc_write=1, value=reset_vector, clear_instruction=1.
  - Next state FLUSH, counter=FLUSH_CYCLES.
  - stall, branch and interrupt are ignored in this cycle.
- Redirect priority in RUN/IMM/FLUSH/HALT: branch_taken > interrupt > stall > normal.
- branch_taken:
  - pc_enable=1, pc_write=1, value=branch_target, clear_instruction=1.
  - Next state FLUSH, counter=FLUSH_CYCLES.
  - Honoured in every state except BOOT, including during stall and IMM.
- interrupt:
  - Accepted only in RUN or HALT, and only without branch_taken.
  - pc_enable=1, pc_write=1, value=interrupt_vector, clear_instruction=1.
  - Next cycle: int_ack=1 for exactly one cycle; int_return_pc = pc_plus_one[15:0] minus 1 (the PC of the discarded word), or pc_plus_one[15:0] when accepted from HALT.
  - Next state FLUSH; halted clears.
  - In IMM or FLUSH the interrupt is deferred, not lost: it is re-evaluated when the state returns to RUN.
- stall (RUN/IMM): pc_enable=0, pc_write=0, clear_instruction=0; state holds.
- RUN, no event: pc_enable=1.
  - instruction[15:13]==IMM_OPCODE gives next state IMM; imm_pending=1 next cycle.
  - instruction[15:11]==HLT_OPCODE gives next state HALT; halted=1 next cycle.
- IMM: pc_enable=1; exactly one cycle (excluding stalls), then RUN. The opcode of the immediate word is not decoded.
- FLUSH:
  - clear_instruction=1, pc_enable=1.
  - Counter decrements every cycle regardless of stall; counter 1 to 0 exits to RUN.
  - A new branch reloads the counter. The opcode of a flushed word is not decoded.
- HALT: pc_enable=0, halted=1; left only by branch_taken, interrupt or reset.
- Reset asserted mid-operation: immediate return to BOOT, outputs 0, pending state discarded.
- pc_write_back_value is 16'h0000 whenever pc_write=0.

Test Plan:
- Boot: reset_vector=16'h0020, release reset -> cycle 1: pc_write=1, value=16'h0020, clear=1; cycle 2: clear=1 (FLUSH); cycle 3: RUN, pc_enable=1, clear=0.
- Stall plus branch: in RUN assert stall 3 cycles -> pc_enable=0 each cycle. Then assert stall and branch_taken with target 16'h0080 together -> pc_write=1, value=16'h0080, clear=1, then 1 flush cycle.
- Two-word: instruction=16'hC123 in RUN -> imm_pending=1 next cycle. Interrupt raised the same cycle -> int_ack is delayed until after IMM and returns 1 cycle after re-entering RUN.
- Interrupt: interrupt_vector=16'h0200, pc_plus_one=32'h0000_0045 in RUN -> pc_write with 16'h0200, then int_ack=1 for one cycle, int_return_pc=16'h0044.
- Halt: instruction=16'h0800 -> halted=1, pc_enable=0 held 10 cycles. Then interrupt -> halted=0, redirect to interrupt_vector.
- Reset mid-flush: assert reset during FLUSH -> all outputs 0 asynchronously; release -> BOOT sequence repeats.
